// File: rtl/kernel_bram_pingpong.sv
// Double-buffered kernel weight store: an AXI-Stream slave fills one BRAM bank
// while the other bank is served one channel word at a time, with optional replay.
module kernel_bram_pingpong #(
  parameter int KERNEL_WIDTH = 16,
  parameter int TAPS         = 9,
  parameter int MAX_CHANNELS = 256,
  parameter int AW           = $clog2(MAX_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic [AW:0]                  CHANNEL_SIZE,
  input  logic                         load_start,
  input  logic [KERNEL_WIDTH*TAPS-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  input  logic                         read_start,
  input  logic                         rd_next,
  input  logic                         rd_keep,
  output logic [KERNEL_WIDTH*TAPS-1:0] kernel_dout,
  output logic                         kernel_dout_valid,
  output logic                         last_loading_1ker,
  output logic                         last_channel,
  output logic [1:0]                   bank_full,
  output logic                         tlast_err
);

  localparam int          DW    = KERNEL_WIDTH * TAPS;
  localparam int          DEPTH = 2 * (2 ** AW);
  localparam logic [AW:0] MAX_N = (AW+1)'(MAX_CHANNELS);
  localparam logic [AW:0] ONE_N = (AW+1)'(1'b1);
  localparam logic [AW-1:0] ONE_A = AW'(1'b1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_LOAD = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rstate_t;

  // Write side state
  wstate_t       r_wstate;
  wstate_t       w_wstate_nxt;
  logic [AW-1:0] r_wa;
  logic [AW-1:0] w_wa_nxt;
  logic [AW:0]   r_wn;
  logic [AW:0]   w_wn_nxt;
  logic          r_wr_bank;
  logic          r_tready;
  logic          r_last_load;
  logic          r_tlast_err;
  logic          w_wbeat;
  logic          w_wfinal;

  // Read side state
  rstate_t       r_rstate;
  rstate_t       w_rstate_nxt;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] w_ra_nxt;
  logic [AW:0]   r_rn;
  logic [AW:0]   w_rn_nxt;
  logic          r_rd_bank;
  logic          r_valid;
  logic          r_last_ch;
  logic          w_valid_nxt;
  logic          w_ren;
  logic [AW-1:0] w_raddr;
  logic          w_release;

  logic [1:0]    r_bank_full;
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_mem [DEPTH];

  logic [AW:0]   w_n;
  logic          w_load_go;
  logic          w_read_go;

  // Effective set size, clamped to the bank depth
  always_comb begin
    if (CHANNEL_SIZE > MAX_N) begin
      w_n = MAX_N;
    end else begin
      w_n = CHANNEL_SIZE;
    end
  end

  assign w_load_go = (r_wstate == W_IDLE) && load_start && (w_n != '0) &&
                     !r_bank_full[r_wr_bank];
  assign w_read_go = (r_rstate == R_IDLE) && read_start && (w_n != '0) &&
                     r_bank_full[r_rd_bank];

  // Write FSM next-state: loading ends on the beat count, never on tlast
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wa_nxt     = r_wa;
    w_wn_nxt     = r_wn;
    w_wbeat      = 1'b0;
    w_wfinal     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_load_go) begin
          w_wstate_nxt = W_LOAD;
          w_wa_nxt     = '0;
          w_wn_nxt     = w_n;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_LOAD: begin
        if (s_axis_tvalid) begin
          w_wbeat = 1'b1;
          if ({1'b0, r_wa} == (r_wn - ONE_N)) begin
            w_wfinal     = 1'b1;
            w_wstate_nxt = W_IDLE;
            w_wa_nxt     = '0;
          end else begin
            w_wa_nxt = r_wa + ONE_A;
          end
        end else begin
          w_wstate_nxt = W_LOAD;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // Write FSM registers and load-side status outputs
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_wstate    <= W_IDLE;
      r_wa        <= '0;
      r_wn        <= '0;
      r_wr_bank   <= 1'b0;
      r_tready    <= 1'b0;
      r_last_load <= 1'b0;
      r_tlast_err <= 1'b0;
    end else begin
      r_wstate    <= w_wstate_nxt;
      r_wa        <= w_wa_nxt;
      r_wn        <= w_wn_nxt;
      r_wr_bank   <= r_wr_bank ^ w_wfinal;
      r_tready    <= (w_wstate_nxt == W_LOAD);
      r_last_load <= w_wfinal;
      r_tlast_err <= r_tlast_err | (w_wbeat && (s_axis_tlast != w_wfinal));
    end
  end

  // Read FSM next-state: r_ra is always the index of the word on kernel_dout
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ra_nxt     = r_ra;
    w_rn_nxt     = r_rn;
    w_ren        = 1'b0;
    w_raddr      = r_ra;
    w_release    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_read_go) begin
          w_rstate_nxt = R_ACTIVE;
          w_ra_nxt     = '0;
          w_rn_nxt     = w_n;
          w_ren        = 1'b1;
          w_raddr      = '0;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_ACTIVE: begin
        if (rd_next && r_valid) begin
          if ({1'b0, r_ra} == (r_rn - ONE_N)) begin
            if (rd_keep) begin
              w_ra_nxt = '0;
              w_ren    = 1'b1;
              w_raddr  = '0;
            end else begin
              w_release    = 1'b1;
              w_rstate_nxt = R_IDLE;
            end
          end else begin
            w_ra_nxt = r_ra + ONE_A;
            w_ren    = 1'b1;
            w_raddr  = r_ra + ONE_A;
          end
        end else begin
          w_rstate_nxt = R_ACTIVE;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  assign w_valid_nxt = (w_rstate_nxt == R_ACTIVE);

  // Read FSM registers and serve-side status outputs
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_rstate  <= R_IDLE;
      r_ra      <= '0;
      r_rn      <= '0;
      r_rd_bank <= 1'b0;
      r_valid   <= 1'b0;
      r_last_ch <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_ra      <= w_ra_nxt;
      r_rn      <= w_rn_nxt;
      r_rd_bank <= r_rd_bank ^ w_release;
      r_valid   <= w_valid_nxt;
      r_last_ch <= w_valid_nxt && ({1'b0, w_ra_nxt} == (w_rn_nxt - ONE_N));
    end
  end

  // Bank ownership flags; set and release never target the same bank
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_bank_full <= 2'b00;
    end else begin
      if (w_wfinal) begin
        r_bank_full[r_wr_bank] <= 1'b1;
      end
      if (w_release) begin
        r_bank_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // BRAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wbeat) begin
      r_mem[{r_wr_bank, r_wa}] <= s_axis_tdata;
    end
  end

  // BRAM registered read port; holds the word until the next read is issued
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_dout <= '0;
    end else if (w_ren) begin
      r_dout <= r_mem[{r_rd_bank, w_raddr}];
    end
  end

  assign s_axis_tready     = r_tready;
  assign kernel_dout       = r_dout;
  assign kernel_dout_valid = r_valid;
  assign last_loading_1ker = r_last_load;
  assign last_channel      = r_last_ch;
  assign bank_full         = r_bank_full;
  assign tlast_err         = r_tlast_err;

endmodule

// File: tb/tb_kernel_bram_pingpong.sv
// Scoreboarded bench for kernel_bram_pingpong: loaded words are queued and
// compared as the read side presents them.
module tb_kernel_bram_pingpong;

  localparam int KW   = 16;
  localparam int TAPS = 9;
  localparam int MAXC = 256;
  localparam int AW   = 8;
  localparam int DW   = KW * TAPS;

  logic          clk;
  logic          Reset;
  logic [AW:0]   CHANNEL_SIZE;
  logic          load_start;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          read_start;
  logic          rd_next;
  logic          rd_keep;
  logic [DW-1:0] kernel_dout;
  logic          kernel_dout_valid;
  logic          last_loading_1ker;
  logic          last_channel;
  logic [1:0]    bank_full;
  logic          tlast_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] sb_q [$];

  kernel_bram_pingpong #(
    .KERNEL_WIDTH(KW), .TAPS(TAPS), .MAX_CHANNELS(MAXC), .AW(AW)
  ) dut (
    .clk(clk), .Reset(Reset), .CHANNEL_SIZE(CHANNEL_SIZE), .load_start(load_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .read_start(read_start), .rd_next(rd_next), .rd_keep(rd_keep),
    .kernel_dout(kernel_dout), .kernel_dout_valid(kernel_dout_valid),
    .last_loading_1ker(last_loading_1ker), .last_channel(last_channel),
    .bank_full(bank_full), .tlast_err(tlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkword(input int i, input bit rnd);
    if (rnd) return {$urandom, $urandom, $urandom, $urandom, 16'(i + 1)};
    else     return DW'(i + 1);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_valid"}, kernel_dout_valid, 0);
    chk({tag, "_dout"}, kernel_dout, 0);
    chk({tag, "_lastload"}, last_loading_1ker, 0);
    chk({tag, "_lastch"}, last_channel, 0);
    chk({tag, "_full"}, bank_full, 0);
    chk({tag, "_terr"}, tlast_err, 0);
  endtask

  // Load one set; every accepted beat is pushed to the scoreboard
  task automatic load_set(input int cs, input int nexp, input int tlast_at, input bit rnd);
    int cnt = 0;
    int cycles = 0;
    int pulses = 0;
    bit acc;
    CHANNEL_SIZE = (AW+1)'(cs);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mkword(0, rnd);
    s_axis_tlast  = (tlast_at == 1);
    while (cnt < nexp && cycles < 2000) begin
      acc = s_axis_tready;
      cyc();
      cycles++;
      if (last_loading_1ker) pulses++;
      if (acc) begin
        sb_q.push_back(s_axis_tdata);
        cnt++;
        s_axis_tdata = mkword(cnt, rnd);
        s_axis_tlast = (tlast_at == cnt + 1);
      end
    end
    chk("load_beats", cnt, nexp);
    chk("load_cycles", cycles, nexp);
    chk("load_pulse", pulses, 1);
    chk("load_tready_low", s_axis_tready, 0);
    cyc();
    chk("load_tready_stays_low", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Serve one set, replaying it 'keeps' times before release
  task automatic read_set(input int cs, input int n, input int keeps, input bit load_on_rel);
    logic [DW-1:0] w [$];
    logic [1:0] bf0;
    for (int i = 0; i < n; i++) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
        w.push_back('0);
      end else begin
        w.push_back(sb_q.pop_front());
      end
    end
    CHANNEL_SIZE = (AW+1)'(cs);
    read_start = 1'b1;
    rd_next    = 1'b1;
    cyc();
    read_start = 1'b0;
    rd_next    = 1'b0;
    chk("rd_valid_lat", kernel_dout_valid, 1);
    bf0 = bank_full;
    for (int r = 0; r <= keeps; r++) begin
      for (int i = 0; i < n; i++) begin
        chk("rd_data", kernel_dout, w[i]);
        chk("rd_valid", kernel_dout_valid, 1);
        chk("rd_last_ch", last_channel, (i == n - 1));
        rd_next = 1'b1;
        rd_keep = (i == n - 1) && (r < keeps);
        if (load_on_rel && i == n - 1 && r == keeps) load_start = 1'b1;
        cyc();
        rd_next = 1'b0;
        rd_keep = 1'b0;
        if (load_on_rel) load_start = 1'b0;
      end
      if (r < keeps) chk("keep_full", bank_full, bf0);
    end
    chk("rel_valid", kernel_dout_valid, 0);
    chk("rel_hold", kernel_dout, w[n - 1]);
    chk("rel_last_ch", last_channel, 0);
  endtask

  initial begin
    Reset = 1'b0; CHANNEL_SIZE = '0; load_start = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    read_start = 1'b0; rd_next = 1'b0; rd_keep = 1'b0;
    cyc(); cyc();
    chk_idle_outputs("reset");
    Reset = 1'b1;
    cyc();

    // Basic load and read
    load_set(4, 4, 4, 1'b0);
    chk("basic_full", bank_full, 2'b01);
    chk("basic_terr", tlast_err, 0);
    read_set(4, 4, 0, 1'b0);
    chk("basic_released", bank_full, 2'b00);

    // Ping-pong: serve one bank while the other loads
    load_set(6, 6, 6, 1'b1);
    fork
      read_set(6, 6, 0, 1'b0);
      load_set(6, 6, 6, 1'b1);
    join
    chk("pp_full", bank_full, 2'b01);
    read_set(6, 6, 0, 1'b0);
    chk("pp_empty", bank_full, 2'b00);

    // Both banks full: load refused; load at release edge refused, retry accepted
    load_set(4, 4, 4, 1'b1);
    load_set(4, 4, 4, 1'b1);
    chk("both_full", bank_full, 2'b11);
    CHANNEL_SIZE = 9'd4;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_tready", s_axis_tready, 0);
      cyc();
    end
    s_axis_tvalid = 1'b0;
    read_set(4, 4, 0, 1'b1);
    chk("rel_load_ignored", s_axis_tready, 0);
    chk("rel_one_full", bank_full, 2'b01);
    load_set(4, 4, 4, 1'b1);
    chk("retry_full", bank_full, 2'b11);
    read_set(4, 4, 0, 1'b0);
    read_set(4, 4, 0, 1'b0);
    chk("drain_empty", bank_full, 2'b00);

    // Retention: replay three times, then release
    load_set(3, 3, 3, 1'b1);
    read_set(3, 3, 3, 1'b0);
    chk("keep_released", bank_full, 2'b00);

    // Single-channel set
    load_set(1, 1, 1, 1'b1);
    read_set(1, 1, 0, 1'b0);

    // Framing error: tlast early, load still counts four beats
    load_set(4, 4, 2, 1'b1);
    chk("framing_terr", tlast_err, 1);
    read_set(4, 4, 0, 1'b0);

    // Zero size ignored
    CHANNEL_SIZE = 9'd0;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    cyc();
    chk("zero_tready", s_axis_tready, 0);
    chk("zero_full", bank_full, 2'b00);

    // Oversized set clamps to the bank depth
    load_set(300, 256, 256, 1'b1);
    read_set(300, 256, 0, 1'b0);
    chk("clamp_empty", bank_full, 2'b00);

    // Reset in the middle of a load
    CHANNEL_SIZE = 9'd8;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_axis_tdata = mkword(i, 1'b1);
      cyc();
    end
    Reset = 1'b0;
    s_axis_tvalid = 1'b0;
    cyc();
    chk_idle_outputs("midreset");
    Reset = 1'b1;
    cyc();
    read_start = 1'b1;
    cyc();
    read_start = 1'b0;
    chk("midreset_no_read", kernel_dout_valid, 0);
    load_set(8, 8, 8, 1'b1);
    read_set(8, 8, 0, 1'b0);
    chk("final_empty", bank_full, 2'b00);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
